// File: rtl/battleship_shot_controller.sv
// Battleship shot controller: validates a scored shot, probes the ship-map
// ROM around the target, classifies the result and keeps the game state
// (hit map, BCD hit count, ships touched, big bombs left, game over).
module battleship_shot_controller #(
    parameter int BIG_BOMBS  = 2,
    parameter int SHIP_CELLS = 17
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       score,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       big,
    output logic [3:0] rom_x,
    output logic [3:0] rom_y,
    input  logic [2:0] rom_ship,
    output logic       hit,
    output logic       near_miss,
    output logic       miss,
    output logic       wrong,
    output logic [3:0] hits_tens,
    output logic [3:0] hits_ones,
    output logic [4:0] ships_hit,
    output logic [1:0] big_left,
    output logic       busy,
    output logic       game_over
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PROBE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    // Probe coordinate {px, py} for probe number idx around (cx, cy).
    // Normal: centre, north, south, west, east. Big: 3x3 row-major.
    function automatic logic [7:0] probe_xy(input logic [3:0] cx, input logic [3:0] cy,
                                            input logic is_big, input logic [3:0] idx);
        logic [3:0] px;
        logic [3:0] py;
        px = cx;
        py = cy;
        if (is_big) begin
            case (idx)
                4'd0: begin px = cx - 4'd1; py = cy - 4'd1; end
                4'd1: begin                 py = cy - 4'd1; end
                4'd2: begin px = cx + 4'd1; py = cy - 4'd1; end
                4'd3: begin px = cx - 4'd1;                 end
                4'd5: begin px = cx + 4'd1;                 end
                4'd6: begin px = cx - 4'd1; py = cy + 4'd1; end
                4'd7: begin                 py = cy + 4'd1; end
                4'd8: begin px = cx + 4'd1; py = cy + 4'd1; end
                default: ;
            endcase
        end else begin
            case (idx)
                4'd1: py = cy - 4'd1;
                4'd2: py = cy + 4'd1;
                4'd3: px = cx - 4'd1;
                4'd4: px = cx + 4'd1;
                default: ;
            endcase
        end
        return {px, py};
    endfunction

    function automatic logic on_board(input logic [7:0] p);
        return (p[7:4] >= 4'd1) && (p[7:4] <= 4'd10) && (p[3:0] >= 4'd1) && (p[3:0] <= 4'd10);
    endfunction

    // Off-board probes park the ROM address at (0,0).
    function automatic logic [7:0] rom_addr(input logic [7:0] p);
        return on_board(p) ? p : 8'h00;
    endfunction

    // Linear hit-map index (y-1)*10 + (x-1) for an on-board cell.
    function automatic logic [6:0] map_index(input logic [7:0] p);
        return 7'(p[3:0]) * 7'd10 + 7'(p[7:4]) - 7'd11;
    endfunction

    state_t       r_state;
    state_t       w_state_next;
    logic         w_busy;
    logic [3:0]   r_x, r_y, r_idx;
    logic         r_big;
    logic [3:0]   r_rom_x, r_rom_y;
    logic [2:0]   r_cell [9];
    logic         r_hit, r_near, r_miss, r_wrong, r_game_over;
    logic [3:0]   r_tens, r_ones;
    logic [4:0]   r_ships;
    logic [1:0]   r_big_left;
    logic [99:0]  r_hit_map;

    logic         w_reject, w_accept, w_capture;
    logic [3:0]   w_last_idx, w_prev_idx;
    logic [7:0]   w_prev_xy, w_first_xy, w_next_xy;

    assign w_reject   = (x < 4'd1) || (x > 4'd10) || (y < 4'd1) || (y > 4'd10) ||
                        (big && (r_big_left == 2'd0));
    assign w_accept   = (r_state == S_IDLE) && score && !r_game_over && !w_reject;
    assign w_last_idx = r_big ? 4'd8 : 4'd4;
    assign w_prev_idx = r_idx - 4'd1;
    assign w_prev_xy  = probe_xy(r_x, r_y, r_big, w_prev_idx);
    assign w_first_xy = rom_addr(probe_xy(x, y, big, 4'd0));
    assign w_next_xy  = rom_addr(probe_xy(r_x, r_y, r_big, r_idx + 4'd1));
    assign w_capture  = ((r_state == S_PROBE) && (r_idx != 4'd0)) || (r_state == S_DRAIN);

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state and busy decode.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = S_PROBE;
            S_PROBE:  if (r_idx == w_last_idx) w_state_next = S_DRAIN;
            S_DRAIN:  w_state_next = S_UPDATE;
            S_UPDATE: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Capture the ROM datum for the probe issued last cycle; off-board reads as empty.
    // NOTE: r_cell is rewritten in full by every shot before it is read, so it has no reset.
    always_ff @(posedge clock) begin
        if (w_capture) r_cell[w_prev_idx] <= on_board(w_prev_xy) ? rom_ship : 3'd0;
    end

    logic [3:0]  w_new_cells;
    logic [99:0] w_map_next;
    logic [4:0]  w_ships_next;
    logic        w_any_hit, w_near;
    logic [7:0]  w_pos;
    logic [4:0]  w_ones_sum;
    logic [3:0]  w_ones_next, w_tens_next;
    logic [6:0]  w_total;

    // Classify the captured cells and build the next game state.
    always_comb begin
        w_new_cells  = 4'd0;
        w_map_next   = r_hit_map;
        w_ships_next = r_ships;
        w_any_hit    = 1'b0;
        w_near       = 1'b0;
        w_pos        = 8'h00;
        for (int i = 0; i < 9; i++) begin
            w_pos = probe_xy(r_x, r_y, r_big, 4'(i));
            if (!r_big && (i >= 1) && (i <= 4) && (r_cell[i] != 3'd0)) w_near = 1'b1;
            if ((r_big || (i == 0)) && (r_cell[i] != 3'd0)) begin
                w_any_hit = 1'b1;
                if (!r_hit_map[map_index(w_pos)]) begin
                    w_map_next[map_index(w_pos)] = 1'b1;
                    w_new_cells = w_new_cells + 4'd1;
                end
                for (int k = 0; k < 5; k++) begin
                    if (r_cell[i] == 3'(k + 1)) w_ships_next[k] = 1'b1;
                end
            end
        end
        w_ones_sum = 5'(r_ones) + 5'(w_new_cells);
        if (w_ones_sum >= 5'd10) begin
            w_ones_next = 4'(w_ones_sum - 5'd10);
            w_tens_next = r_tens + 4'd1;
        end else begin
            w_ones_next = 4'(w_ones_sum);
            w_tens_next = r_tens;
        end
        w_total = 7'(w_tens_next) * 7'd10 + 7'(w_ones_next);
    end

    // Shot acceptance, probe address sequencing and end-of-shot update.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_x <= 4'd0;  r_y <= 4'd0;  r_big <= 1'b0;  r_idx <= 4'd0;
            r_rom_x <= 4'd0;  r_rom_y <= 4'd0;
            r_hit <= 1'b0;  r_near <= 1'b0;  r_miss <= 1'b0;  r_wrong <= 1'b0;
            r_game_over <= 1'b0;
            r_tens <= 4'd0;  r_ones <= 4'd0;  r_ships <= 5'd0;
            r_big_left <= 2'(BIG_BOMBS);
            r_hit_map <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (score && !r_game_over) begin
                        if (w_reject) begin
                            r_wrong <= 1'b1;
                        end else begin
                            r_wrong <= 1'b0;
                            r_x <= x;  r_y <= y;  r_big <= big;  r_idx <= 4'd0;
                            {r_rom_x, r_rom_y} <= w_first_xy;
                        end
                    end
                end
                S_PROBE: begin
                    r_idx <= r_idx + 4'd1;
                    if (r_idx == w_last_idx) {r_rom_x, r_rom_y} <= 8'h00;
                    else                     {r_rom_x, r_rom_y} <= w_next_xy;
                end
                S_UPDATE: begin
                    r_hit     <= w_any_hit;
                    r_near    <= !w_any_hit && w_near;
                    r_miss    <= !w_any_hit && !w_near;
                    r_hit_map <= w_map_next;
                    r_ships   <= w_ships_next;
                    r_tens    <= w_tens_next;
                    r_ones    <= w_ones_next;
                    if (r_big) r_big_left <= r_big_left - 2'd1;
                    if (int'(w_total) >= SHIP_CELLS) r_game_over <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rom_x     = r_rom_x;
    assign rom_y     = r_rom_y;
    assign hit       = r_hit;
    assign near_miss = r_near;
    assign miss      = r_miss;
    assign wrong     = r_wrong;
    assign hits_tens = r_tens;
    assign hits_ones = r_ones;
    assign ships_hit = r_ships;
    assign big_left  = r_big_left;
    assign busy      = w_busy;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_battleship_shot_controller.sv
// Directed bench for battleship_shot_controller with a 1-cycle registered
// ship-map ROM model; board cell (0,0) holds a non-zero sentinel so that
// off-board probes must be masked by the controller.
module tb_battleship_shot_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       score = 1'b0;
    logic [3:0] x = 4'd0, y = 4'd0;
    logic       big = 1'b0;
    logic [3:0] rom_x, rom_y;
    logic [2:0] rom_ship = 3'd0;
    logic       hit, near_miss, miss, wrong, busy, game_over;
    logic [3:0] hits_tens, hits_ones;
    logic [4:0] ships_hit;
    logic [1:0] big_left;

    logic [2:0] board [0:15][0:15];
    logic [3:0] cap_x [0:15];
    logic [3:0] cap_y [0:15];
    logic [3:0] flags;
    logic [7:0] count;
    int         n_pass = 0;
    int         n_total = 0;
    int         lat;

    assign flags = {hit, near_miss, miss, wrong};
    assign count = {hits_tens, hits_ones};

    battleship_shot_controller #(.BIG_BOMBS(2), .SHIP_CELLS(17)) dut (
        .clock(clock), .reset(reset), .score(score), .x(x), .y(y), .big(big),
        .rom_x(rom_x), .rom_y(rom_y), .rom_ship(rom_ship),
        .hit(hit), .near_miss(near_miss), .miss(miss), .wrong(wrong),
        .hits_tens(hits_tens), .hits_ones(hits_ones), .ships_hit(ships_hit),
        .big_left(big_left), .busy(busy), .game_over(game_over)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_ship <= board[rom_y][rom_x];

    task automatic clear_board();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) board[r][c] = 3'd0;
        board[0][0] = 3'd7;
    endtask

    task automatic do_reset();
        @(negedge clock); reset = 1'b1; score = 1'b0;
        @(negedge clock); reset = 1'b0;
    endtask

    // Pulse score for one cycle; returns in the middle of cycle T+1.
    task automatic fire(input logic [3:0] fx, input logic [3:0] fy, input logic fb);
        @(negedge clock); x = fx; y = fy; big = fb; score = 1'b1;
        @(negedge clock); score = 1'b0; x = 4'hF; y = 4'hF; big = 1'b0;
    endtask

    // Follow busy (bounded), recording the ROM address seen each cycle.
    task automatic wait_done(input int start);
        lat = start;
        cap_x[lat-1] = rom_x; cap_y[lat-1] = rom_y;
        while (busy === 1'b1 && lat < 30) begin
            @(negedge clock);
            lat++;
            if (lat <= 16) begin cap_x[lat-1] = rom_x; cap_y[lat-1] = rom_y; end
        end
    endtask

    function automatic logic [71:0] caps(input int n);
        logic [71:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[63:0], cap_x[i], cap_y[i]};
        return v;
    endfunction

    task automatic test_reset();
        do_reset();
        n_total++; if (flags !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", flags); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (count !== 8'h00) $display("FAIL reset_count: got %h want 00", count); else n_pass++;
        n_total++; if (ships_hit !== 5'd0) $display("FAIL reset_ships: got %b want 00000", ships_hit); else n_pass++;
        n_total++; if (big_left !== 2'd2) $display("FAIL reset_big_left: got %0d want 2", big_left); else n_pass++;
        n_total++; if (game_over !== 1'b0) $display("FAIL reset_game_over: got %b want 0", game_over); else n_pass++;
        n_total++; if ({rom_x, rom_y} !== 8'h00) $display("FAIL reset_rom: got %h want 00", {rom_x, rom_y}); else n_pass++;
    endtask

    task automatic test_reject();
        clear_board(); do_reset();
        fire(4'd0, 4'd5, 1'b0);
        n_total++; if (flags !== 4'b0001) $display("FAIL rej_x0_flags: got %b want 0001", flags); else n_pass++;
        wait_done(1);
        n_total++; if (lat !== 1) $display("FAIL rej_x0_busy: busy cycles %0d want 1 (never busy)", lat); else n_pass++;
        n_total++; if (count !== 8'h00) $display("FAIL rej_x0_count: got %h want 00", count); else n_pass++;
        fire(4'd11, 4'd3, 1'b0);
        n_total++; if ({flags, busy} !== 5'b00010) $display("FAIL rej_x11: got %b want 00010", {flags, busy}); else n_pass++;
        fire(4'd4, 4'd0, 1'b0);
        n_total++; if ({flags, busy} !== 5'b00010) $display("FAIL rej_y0: got %b want 00010", {flags, busy}); else n_pass++;
        fire(4'd4, 4'd4, 1'b0);
        n_total++; if ({wrong, busy} !== 2'b01) $display("FAIL accept_t1: wrong,busy=%b want 01", {wrong, busy}); else n_pass++;
        wait_done(1);
        n_total++; if (lat !== 8) $display("FAIL accept_latency: got %0d want 8", lat); else n_pass++;
        n_total++; if (flags !== 4'b0010) $display("FAIL accept_miss: got %b want 0010", flags); else n_pass++;
    endtask

    task automatic test_hit();
        clear_board(); board[3][3] = 3'd1; do_reset();
        fire(4'd3, 4'd3, 1'b0); wait_done(1);
        n_total++; if (lat !== 8) $display("FAIL hit_latency: got %0d want 8", lat); else n_pass++;
        n_total++; if (caps(5) !== 72'h33_32_34_23_43) $display("FAIL hit_probe_order: got %h want 3332342343", caps(5)); else n_pass++;
        n_total++; if (flags !== 4'b1000) $display("FAIL hit_flags: got %b want 1000", flags); else n_pass++;
        n_total++; if (count !== 8'h01) $display("FAIL hit_count: got %h want 01", count); else n_pass++;
        n_total++; if (ships_hit !== 5'b00001) $display("FAIL hit_ships: got %b want 00001", ships_hit); else n_pass++;
        fire(4'd3, 4'd3, 1'b0); wait_done(1);
        n_total++; if (flags !== 4'b1000) $display("FAIL rehit_flags: got %b want 1000", flags); else n_pass++;
        n_total++; if (count !== 8'h01) $display("FAIL rehit_count: got %h want 01", count); else n_pass++;
    endtask

    task automatic test_near_miss();
        clear_board(); board[6][5] = 3'd2; board[2][8] = 3'd4; do_reset();
        fire(4'd5, 4'd5, 1'b0); wait_done(1);
        n_total++; if (flags !== 4'b0100) $display("FAIL near_south: got %b want 0100", flags); else n_pass++;
        n_total++; if ({count, ships_hit} !== 13'd0) $display("FAIL near_no_count: got %h/%b want 00/00000", count, ships_hit); else n_pass++;
        fire(4'd9, 4'd9, 1'b0); wait_done(1);
        n_total++; if (flags !== 4'b0010) $display("FAIL miss_open: got %b want 0010", flags); else n_pass++;
        fire(4'd7, 4'd2, 1'b0); wait_done(1);
        n_total++; if (flags !== 4'b0100) $display("FAIL near_east: got %b want 0100", flags); else n_pass++;
        fire(4'd1, 4'd5, 1'b0); wait_done(1);
        n_total++; if (flags !== 4'b0010) $display("FAIL miss_edge: got %b want 0010", flags); else n_pass++;
        n_total++; if ({cap_x[3], cap_y[3]} !== 8'h00) $display("FAIL offboard_addr: got %h want 00", {cap_x[3], cap_y[3]}); else n_pass++;
    endtask

    task automatic test_big();
        clear_board(); board[1][1] = 3'd1; board[1][2] = 3'd1; board[2][1] = 3'd3; board[7][7] = 3'd5;
        do_reset();
        fire(4'd1, 4'd1, 1'b1); wait_done(1);
        n_total++; if (lat !== 12) $display("FAIL big_latency: got %0d want 12", lat); else n_pass++;
        n_total++; if (caps(9) !== 72'h00_00_00_00_11_21_00_12_22) $display("FAIL big_probe_order: got %h want 000000001121001222", caps(9)); else n_pass++;
        n_total++; if (flags !== 4'b1000) $display("FAIL big_corner_flags: got %b want 1000", flags); else n_pass++;
        n_total++; if (count !== 8'h03) $display("FAIL big_corner_count: got %h want 03", count); else n_pass++;
        n_total++; if (big_left !== 2'd1) $display("FAIL big_left_1: got %0d want 1", big_left); else n_pass++;
        n_total++; if (ships_hit !== 5'b00101) $display("FAIL big_ships: got %b want 00101", ships_hit); else n_pass++;
        fire(4'd8, 4'd8, 1'b1); wait_done(1);
        n_total++; if ({flags, count} !== 12'b1000_0000_0100) $display("FAIL big_offcentre: got %b/%h want 1000/04", flags, count); else n_pass++;
        n_total++; if ({big_left, ships_hit} !== 7'b00_10101) $display("FAIL big_second: got %0d/%b want 0/10101", big_left, ships_hit); else n_pass++;
        fire(4'd5, 4'd5, 1'b1);
        n_total++; if ({flags, busy} !== 5'b10010) $display("FAIL big_none_left: got %b want 10010", {flags, busy}); else n_pass++;
        n_total++; if (big_left !== 2'd0) $display("FAIL big_left_0: got %0d want 0", big_left); else n_pass++;
        fire(4'd9, 4'd9, 1'b0); wait_done(1);
        n_total++; if (flags !== 4'b0010) $display("FAIL normal_after_big: got %b want 0010", flags); else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_board(); board[3][3] = 3'd1; board[9][9] = 3'd2; do_reset();
        fire(4'd3, 4'd3, 1'b0);
        @(negedge clock); x = 4'd9; y = 4'd9; score = 1'b1;
        @(negedge clock); score = 1'b0; x = 4'hF; y = 4'hF;
        wait_done(3);
        n_total++; if (lat !== 8) $display("FAIL busy_pulse_latency: got %0d want 8", lat); else n_pass++;
        n_total++; if ({flags, count} !== 12'b1000_0000_0001) $display("FAIL busy_pulse_result: got %b/%h want 1000/01", flags, count); else n_pass++;
        n_total++; if (ships_hit !== 5'b00001) $display("FAIL busy_pulse_ships: got %b want 00001", ships_hit); else n_pass++;
        repeat (3) @(negedge clock);
        n_total++; if ({busy, wrong} !== 2'b00) $display("FAIL busy_pulse_dropped: busy,wrong=%b want 00", {busy, wrong}); else n_pass++;
    endtask

    task automatic test_game_over();
        logic [7:0] shots [0:12];
        logic [0:12] is_big;
        shots = '{8'h42, 8'h52, 8'h45, 8'h18, 8'h28, 8'h38, 8'h91, 8'h92,
                  8'h22, 8'h25, 8'h93, 8'h7A, 8'h8A};
        is_big = 13'b0000_0000_1100_0;
        clear_board();
        for (int c = 1; c <= 5; c++) board[2][c] = 3'd1;
        for (int c = 1; c <= 4; c++) board[5][c] = 3'd2;
        for (int c = 1; c <= 3; c++) board[8][c] = 3'd3;
        for (int r = 1; r <= 3; r++) board[r][9] = 3'd4;
        board[10][7] = 3'd5; board[10][8] = 3'd5;
        do_reset();
        for (int s = 0; s < 13; s++) begin
            fire(shots[s][7:4], shots[s][3:0], is_big[s]); wait_done(1);
            n_total++; if (hit !== 1'b1) $display("FAIL go_shot%0d_hit: got %b want 1", s, hit); else n_pass++;
            if (s == 7) begin
                n_total++; if (count !== 8'h08) $display("FAIL go_count8: got %h want 08", count); else n_pass++;
            end
            if (s == 8) begin
                n_total++; if ({count, game_over} !== 9'b0001_0001_0) $display("FAIL go_bcd_carry: got %h/%b want 11/0", count, game_over); else n_pass++;
            end
        end
        n_total++; if (count !== 8'h17) $display("FAIL go_count17: got %h want 17", count); else n_pass++;
        n_total++; if (game_over !== 1'b1) $display("FAIL go_flag: got %b want 1", game_over); else n_pass++;
        n_total++; if (ships_hit !== 5'b11111) $display("FAIL go_ships: got %b want 11111", ships_hit); else n_pass++;
        fire(4'd4, 4'd4, 1'b0); wait_done(1);
        n_total++; if ({lat == 1, flags} !== 5'b11000) $display("FAIL go_ignore_valid: never_busy,flags=%b want 11000", {lat == 1, flags}); else n_pass++;
        fire(4'd0, 4'd0, 1'b0);
        n_total++; if ({flags, busy, count} !== 13'b1000_0_0001_0111) $display("FAIL go_ignore_bad: got %b/%b/%h want 1000/0/17", flags, busy, count); else n_pass++;
    endtask

    task automatic test_reset_mid_shot();
        clear_board(); board[3][3] = 3'd1; do_reset();
        fire(4'd3, 4'd3, 1'b1);
        @(negedge clock); @(negedge clock); reset = 1'b1;
        @(negedge clock);
        n_total++; if ({flags, busy, game_over} !== 6'b0) $display("FAIL midrst_flags: got %b want 000000", {flags, busy, game_over}); else n_pass++;
        n_total++; if ({count, ships_hit, big_left} !== 15'b0000_0000_00000_10) $display("FAIL midrst_state: got %h/%b/%0d want 00/00000/2", count, ships_hit, big_left); else n_pass++;
        n_total++; if ({rom_x, rom_y} !== 8'h00) $display("FAIL midrst_rom: got %h want 00", {rom_x, rom_y}); else n_pass++;
        reset = 1'b0;
        repeat (15) @(negedge clock);
        n_total++; if ({flags, busy, count, big_left} !== 15'b0000_0_0000_0000_10) $display("FAIL midrst_no_leak: got %b/%b/%h/%0d want 0000/0/00/2", flags, busy, count, big_left); else n_pass++;
        fire(4'd3, 4'd3, 1'b0); wait_done(1);
        n_total++; if ({flags, count} !== 12'b1000_0000_0001) $display("FAIL midrst_fresh_hit: got %b/%h want 1000/01", flags, count); else n_pass++;
    endtask

    initial begin
        clear_board();
        test_reset();
        test_reject();
        test_hit();
        test_near_miss();
        test_big();
        test_back_to_back();
        test_game_over();
        test_reset_mid_shot();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
